// File: rtl/sha1_pkg.sv
// ============================================================================
// Module   : sha1_pkg
// Purpose  : Shared definitions for the SHA-1 message loader: loader state
//            encoding, digest width and the SHA-1 initial hash values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha1_pkg;

  localparam int c_DIGEST_W = 160;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  localparam logic [31:0] c_SHA1_H0 = 32'h67452301;
  localparam logic [31:0] c_SHA1_H1 = 32'hefcdab89;
  localparam logic [31:0] c_SHA1_H2 = 32'h98badcfe;
  localparam logic [31:0] c_SHA1_H3 = 32'h10325476;
  localparam logic [31:0] c_SHA1_H4 = 32'hc3d2e1f0;

  localparam logic [c_DIGEST_W-1:0] c_SHA1_IV =
    {c_SHA1_H0, c_SHA1_H1, c_SHA1_H2, c_SHA1_H3, c_SHA1_H4};

endpackage

`default_nettype wire

// File: rtl/sha1_byte_packer.sv
// ============================================================================
// Module   : sha1_byte_packer
// Purpose  : Packs accepted stream bytes little-endian into 32-bit words and
//            emits a one-cycle registered write strobe per completed word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha1_byte_packer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data,
  input  logic              last,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output logic [31:0]       byte_cnt
);

  logic [31:0]       r_word;
  logic [ADDR_W-3:0] r_word_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_byte_cnt;

  logic [1:0]        w_lane;
  logic [31:0]       w_merged;
  logic              w_complete;

  // Byte 0 lands in the LSBs; the hasher byte-swaps when it reads the word.
  // Lanes above the current one are still zero, so OR-merging is safe.
  assign w_lane     = r_byte_cnt[1:0];
  assign w_merged   = r_word | ({24'h000000, data} << {w_lane, 3'b000});
  assign w_complete = accept & ((w_lane == 2'd3) | last);

  // Lane accumulation and one-deep write pipeline; a last byte that also
  // fills lane 3 still yields a single completion and thus a single write.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_word     <= 32'h0;
      r_word_idx <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_byte_cnt <= 32'h0;
    end else if (clear) begin
      r_word     <= 32'h0;
      r_word_idx <= '0;
      r_we       <= 1'b0;
      r_byte_cnt <= 32'h0;
    end else begin
      r_we <= w_complete;
      if (accept) begin
        r_byte_cnt <= r_byte_cnt + 32'd1;
        if (w_complete) begin
          r_word     <= 32'h0;
          r_wdata    <= w_merged;
          r_addr     <= base_addr + {r_word_idx, 2'b00};
          r_word_idx <= r_word_idx + (ADDR_W-2)'(1);
        end else begin
          r_word <= w_merged;
        end
      end
    end
  end

  assign we       = r_we;
  assign addr     = r_addr;
  assign wdata    = r_wdata;
  assign byte_cnt = r_byte_cnt;

endmodule

`default_nettype wire

// File: rtl/sha1_msg_loader.sv
// ============================================================================
// Module   : sha1_msg_loader
// Purpose  : Writer-side front end for the SHA-1 hasher. Streams a message
//            into dpsram port A, kicks the hasher and captures the digest.
//            Optional macro SHA1_LOADER_TIMEOUT_EN adds a 2^20-cycle watchdog
//            in WAIT and the hash_timeout output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha1_msg_loader
  import sha1_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int HOLDOFF = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  load_start,
  input  logic                  load_empty,
  input  logic [31:0]           msg_base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  port_A_clk,
  output logic [ADDR_W-1:0]     port_A_addr,
  output logic [31:0]           port_A_data_in,
  output logic                  port_A_we,
  output logic                  port_sel,
  output logic                  start_hash,
  output logic [31:0]           message_addr,
  output logic [31:0]           message_size,
  input  logic                  hash_done,
  input  logic [c_DIGEST_W-1:0] hash_in,
  output logic [c_DIGEST_W-1:0] digest,
  output logic                  digest_valid,
`ifdef SHA1_LOADER_TIMEOUT_EN
  output logic                  hash_timeout,
`endif
  output logic                  busy
);

  localparam logic [7:0] c_HOLDOFF = 8'(HOLDOFF);

  state_t                r_state;
  logic [31:0]           r_base;
  logic                  r_in_ready;
  logic                  r_port_sel;
  logic                  r_start_hash;
  logic [31:0]           r_message_addr;
  logic [31:0]           r_message_size;
  logic [c_DIGEST_W-1:0] r_digest;
  logic                  r_digest_valid;
  logic [7:0]            r_hold;
`ifdef SHA1_LOADER_TIMEOUT_EN
  logic [19:0]           r_wdog;
  logic                  r_hash_timeout;
`endif

  logic                  w_accept;
  logic                  w_clear;
  logic [31:0]           w_byte_cnt;

  assign w_accept = in_valid & r_in_ready;
  assign w_clear  = (r_state == ST_IDLE) & load_start;

  sha1_byte_packer #(
    .ADDR_W    (ADDR_W)
  ) u_packer (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (w_clear),
    .accept    (w_accept),
    .data      (in_data),
    .last      (in_last),
    .base_addr (r_base[ADDR_W-1:0]),
    .we        (port_A_we),
    .addr      (port_A_addr),
    .wdata     (port_A_data_in),
    .byte_cnt  (w_byte_cnt)
  );

  // Loader control FSM; every control output is registered on entry to the
  // state that owns it, so it is valid for that state's whole cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state        <= ST_IDLE;
      r_base         <= 32'h0;
      r_in_ready     <= 1'b0;
      r_port_sel     <= 1'b0;
      r_start_hash   <= 1'b0;
      r_message_addr <= 32'h0;
      r_message_size <= 32'h0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_hold         <= 8'd0;
`ifdef SHA1_LOADER_TIMEOUT_EN
      r_wdog         <= 20'd0;
      r_hash_timeout <= 1'b0;
`endif
    end else begin
      r_start_hash   <= 1'b0;
      r_digest_valid <= 1'b0;
`ifdef SHA1_LOADER_TIMEOUT_EN
      r_hash_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_base <= msg_base_addr;
            if (load_empty) begin
              r_state        <= ST_START;
              r_start_hash   <= 1'b1;
              r_message_addr <= msg_base_addr;
              r_message_size <= 32'h0;
            end else begin
              r_state    <= ST_FILL;
              r_in_ready <= 1'b1;
              r_port_sel <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (w_accept && in_last) begin
            r_state    <= ST_FLUSH;
            r_in_ready <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // The final word is written this cycle; byte_cnt is already final.
          r_state        <= ST_START;
          r_port_sel     <= 1'b0;
          r_start_hash   <= 1'b1;
          r_message_addr <= r_base;
          r_message_size <= w_byte_cnt;
        end
        ST_START: begin
          r_state <= ST_WAIT;
          r_hold  <= c_HOLDOFF;
`ifdef SHA1_LOADER_TIMEOUT_EN
          r_wdog  <= 20'd0;
`endif
        end
        ST_WAIT: begin
`ifdef SHA1_LOADER_TIMEOUT_EN
          r_wdog <= r_wdog + 20'd1;
`endif
          if (r_hold != 8'd0) begin
            r_hold <= r_hold - 8'd1;
          end else if (hash_done) begin
            r_digest       <= hash_in;
            r_digest_valid <= 1'b1;
            r_state        <= ST_IDLE;
          end
`ifdef SHA1_LOADER_TIMEOUT_EN
          else if (r_wdog == 20'hFFFFF) begin
            r_hash_timeout <= 1'b1;
            r_state        <= ST_IDLE;
          end
`endif
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_port_sel <= 1'b0;
        end
      endcase
    end
  end

  assign port_A_clk   = clk;
  assign in_ready     = r_in_ready;
  assign port_sel     = r_port_sel;
  assign start_hash   = r_start_hash;
  assign message_addr = r_message_addr;
  assign message_size = r_message_size;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign busy         = (r_state != ST_IDLE);
`ifdef SHA1_LOADER_TIMEOUT_EN
  assign hash_timeout = r_hash_timeout;
`endif

endmodule

`default_nettype wire
